savestate_ddr_seq: RTL and testbench

- Sequences whole-block save-state transfers through the 32-bit save-state channel of the DDRAM multiplexer.
- On save, pulls words from the core's save-state source and writes them to DDRAM as a payload followed by a 2-word header. The magic word is written last, so an interrupted save never validates.
- On load, validates the header and streams the payload to the core's save-state sink.
- Sits between the core save-state logic and the multiplexer's ch4 port.

---
 rtl/savestate_pkg.sv | 26 ++
 rtl/savestate_mem_port.sv | 52 +++++
 rtl/savestate_ddr_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_savestate_ddr_seq.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/savestate_pkg.sv
// Shared types and constants for the save-state DDRAM sequencer.
// Offsets are in halfword units, matching the ch4 address.
package savestate_pkg;

    localparam logic [31:0] MAGIC_DEFAULT     = 32'h47424153;
    localparam logic [15:0] MAX_WORDS_DEFAULT = 16'd32768;

    localparam int unsigned HDR0_OFS    = 0;
    localparam int unsigned HDR1_OFS    = 2;
    localparam int unsigned PAYLOAD_OFS = 4;
    localparam int unsigned WORD_STRIDE = 2;

    typedef enum logic [3:0] {
        StIdle,
        StSFetch,
        StSWr,
        StSHdr1,
        StSHdr0,
        StLHdr0,
        StLHdr1,
        StLRd,
        StLPush,
        StFin
    } state_e;

endpackage

// File: rtl/savestate_mem_port.sv
// Single-outstanding request port for the ch4 channel: registers the request,
// holds address/data until ready, and flags completion of the outstanding access.
module savestate_mem_port #(
    parameter int unsigned ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue,
    input  logic              issue_rnw,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [31:0]       issue_data,
    output logic              pending,
    output logic              complete,
    output logic [31:0]       rd_data,
    output logic              mem_req,
    output logic              mem_rnw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_dout,
    input  logic [31:0]       mem_din,
    input  logic              mem_ready
);

    logic pending_q;
    logic accept;

    // A ready with nothing outstanding (e.g. after a reset) is dropped here.
    assign complete = pending_q & mem_ready;
    assign accept   = issue & (~pending_q | complete);
    assign pending  = pending_q;
    assign rd_data  = mem_din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            mem_req   <= 1'b0;
            mem_rnw   <= 1'b0;
            mem_addr  <= '0;
            mem_dout  <= '0;
        end else begin
            mem_req <= accept;
            if (accept) begin
                pending_q <= 1'b1;
                mem_rnw   <= issue_rnw;
                mem_addr  <= issue_addr;
                mem_dout  <= issue_data;
            end else if (complete) begin
                pending_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/savestate_ddr_seq.sv
// Save-state DDRAM sequencer: saves payload then header (magic last) and
// loads by validating the header before streaming the payload to the sink.
module savestate_ddr_seq
    import savestate_pkg::*;
#(
    parameter logic [31:0] MAGIC     = MAGIC_DEFAULT,
    parameter logic [15:0] MAX_WORDS = MAX_WORDS_DEFAULT,
    parameter int unsigned ADDR_W    = 24
) (
    input  logic              DDRAM_CLK,
    input  logic              reset_n,
    input  logic              save_start,
    input  logic              load_start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       word_count,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       load_count,
    output logic              src_req,
    input  logic [31:0]       src_data,
    input  logic              src_ack,
    output logic              snk_valid,
    output logic [31:0]       snk_data,
    input  logic              snk_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_dout,
    input  logic [31:0]       mem_din,
    output logic              mem_req,
    output logic              mem_rnw,
    input  logic              mem_ready
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [15:0]       count_q, count_d;
    logic [15:0]       idx_q, idx_d;
    logic [15:0]       load_count_q, load_count_d;
    logic [31:0]       snk_data_q, snk_data_d;
    logic              abort_q, abort_d;
    logic              error_q, error_d;

    logic              issue, issue_rnw;
    logic [ADDR_W-1:0] issue_addr;
    logic [31:0]       issue_data;
    logic              pending, complete;
    logic [31:0]       rd_data;
    logic              abortable;

    function automatic logic [ADDR_W-1:0] pay_addr(input logic [ADDR_W-1:0] b,
                                                   input logic [15:0] i);
        return b + ADDR_W'(PAYLOAD_OFS) + ADDR_W'(WORD_STRIDE) * ADDR_W'(i);
    endfunction

    savestate_mem_port #(
        .ADDR_W(ADDR_W)
    ) u_mem_port (
        .clk       (DDRAM_CLK),
        .rst_n     (reset_n),
        .issue     (issue),
        .issue_rnw (issue_rnw),
        .issue_addr(issue_addr),
        .issue_data(issue_data),
        .pending   (pending),
        .complete  (complete),
        .rd_data   (rd_data),
        .mem_req   (mem_req),
        .mem_rnw   (mem_rnw),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din),
        .mem_ready (mem_ready)
    );

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        count_d      = count_q;
        idx_d        = idx_q;
        load_count_d = load_count_q;
        snk_data_d   = snk_data_q;
        abort_d      = abort_q;
        error_d      = 1'b0;
        issue        = 1'b0;
        issue_rnw    = 1'b0;
        issue_addr   = base_q;
        issue_data   = 32'h0;
        // Once the magic write is issued the image is committed; let it finish.
        abortable    = !(state_q inside {StIdle, StFin, StSHdr0});

        if (abortable && (abort || abort_q)) begin
            if (pending && !complete) begin
                abort_d = 1'b1;
            end else begin
                abort_d = 1'b0;
                error_d = 1'b1;
                state_d = StIdle;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (save_start) begin
                        if (word_count == 16'd0 || word_count > MAX_WORDS) begin
                            error_d = 1'b1;
                        end else begin
                            base_d  = base_addr;
                            count_d = word_count;
                            idx_d   = 16'd0;
                            state_d = StSFetch;
                        end
                    end else if (load_start) begin
                        base_d     = base_addr;
                        idx_d      = 16'd0;
                        issue      = 1'b1;
                        issue_rnw  = 1'b1;
                        issue_addr = base_addr + ADDR_W'(HDR0_OFS);
                        state_d    = StLHdr0;
                    end
                end
                StSFetch: begin
                    if (src_ack) begin
                        issue      = 1'b1;
                        issue_addr = pay_addr(base_q, idx_q);
                        issue_data = src_data;
                        state_d    = StSWr;
                    end
                end
                StSWr: begin
                    if (complete) begin
                        idx_d = idx_q + 16'd1;
                        if (idx_q + 16'd1 == count_q) begin
                            issue      = 1'b1;
                            issue_addr = base_q + ADDR_W'(HDR1_OFS);
                            issue_data = {16'h0, count_q};
                            state_d    = StSHdr1;
                        end else begin
                            state_d = StSFetch;
                        end
                    end
                end
                StSHdr1: begin
                    if (complete) begin
                        issue      = 1'b1;
                        issue_addr = base_q + ADDR_W'(HDR0_OFS);
                        issue_data = MAGIC;
                        state_d    = StSHdr0;
                    end
                end
                StSHdr0: begin
                    if (complete) state_d = StFin;
                end
                StLHdr0: begin
                    if (complete) begin
                        if (rd_data != MAGIC) begin
                            error_d = 1'b1;
                            state_d = StIdle;
                        end else begin
                            issue      = 1'b1;
                            issue_rnw  = 1'b1;
                            issue_addr = base_q + ADDR_W'(HDR1_OFS);
                            state_d    = StLHdr1;
                        end
                    end
                end
                StLHdr1: begin
                    if (complete) begin
                        if (rd_data[31:16] != 16'h0 || rd_data[15:0] == 16'd0 ||
                            rd_data[15:0] > MAX_WORDS) begin
                            error_d = 1'b1;
                            state_d = StIdle;
                        end else begin
                            load_count_d = rd_data[15:0];
                            count_d      = rd_data[15:0];
                            issue        = 1'b1;
                            issue_rnw    = 1'b1;
                            issue_addr   = pay_addr(base_q, 16'd0);
                            state_d      = StLRd;
                        end
                    end
                end
                StLRd: begin
                    if (complete) begin
                        snk_data_d = rd_data;
                        state_d    = StLPush;
                    end
                end
                StLPush: begin
                    if (snk_ack) begin
                        idx_d = idx_q + 16'd1;
                        if (idx_q + 16'd1 == count_q) begin
                            state_d = StFin;
                        end else begin
                            issue      = 1'b1;
                            issue_rnw  = 1'b1;
                            issue_addr = pay_addr(base_q, idx_q + 16'd1);
                            state_d    = StLRd;
                        end
                    end
                end
                StFin:   state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge DDRAM_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            base_q       <= '0;
            count_q      <= 16'd0;
            idx_q        <= 16'd0;
            load_count_q <= 16'd0;
            snk_data_q   <= 32'h0;
            abort_q      <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            load_count_q <= load_count_d;
            snk_data_q   <= snk_data_d;
            abort_q      <= abort_d;
            error_q      <= error_d;
        end
    end

    assign busy       = (state_q != StIdle) && (state_q != StFin);
    assign done       = (state_q == StFin);
    assign error      = error_q;
    assign load_count = load_count_q;
    assign src_req    = (state_q == StSFetch) && !abort_q;
    assign snk_valid  = (state_q == StLPush) && !abort_q;
    assign snk_data   = snk_data_q;

endmodule

// File: tb/tb_savestate_ddr_seq.sv
// Self-checking bench for savestate_ddr_seq: behavioural DDRAM, source and sink
// models, a table of legality vectors, directed corner cases and random save/load pairs.
module tb_savestate_ddr_seq;

    localparam logic [31:0] MAGIC_W = 32'h47424153;

    logic        clk = 1'b0;
    logic        reset_n, save_start, load_start, abort;
    logic [23:0] base_addr;
    logic [15:0] word_count;
    logic        busy, done, error;
    logic [15:0] load_count;
    logic        src_req, src_ack;
    logic [31:0] src_data;
    logic        snk_valid, snk_ack;
    logic [31:0] snk_data;
    logic [23:0] mem_addr;
    logic [31:0] mem_dout, mem_din;
    logic        mem_req, mem_rnw, mem_ready;

    always #5 clk = ~clk;

    savestate_ddr_seq dut (
        .DDRAM_CLK (clk),
        .reset_n   (reset_n),
        .save_start(save_start),
        .load_start(load_start),
        .abort     (abort),
        .base_addr (base_addr),
        .word_count(word_count),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .load_count(load_count),
        .src_req   (src_req),
        .src_data  (src_data),
        .src_ack   (src_ack),
        .snk_valid (snk_valid),
        .snk_data  (snk_data),
        .snk_ack   (snk_ack),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din),
        .mem_req   (mem_req),
        .mem_rnw   (mem_rnw),
        .mem_ready (mem_ready)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- DDRAM model ----------------
    logic [31:0] mem [logic [23:0]];
    int          wr_cnt [logic [23:0]];
    logic [23:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          req_cnt = 0, ready_cnt = 0;
    int unsigned mem_lat_min = 0, mem_lat_max = 0;
    bit          m_pend = 1'b0;
    int unsigned m_cnt = 0;
    logic [23:0] m_addr;
    logic [31:0] m_data;
    logic        m_rnw;

    function automatic logic [31:0] rd_mem(input logic [23:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    initial begin
        mem_ready = 1'b0;
        mem_din   = 32'h0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (m_pend) begin
                if (m_cnt == 0) begin
                    m_pend    = 1'b0;
                    mem_ready = 1'b1;
                    ready_cnt++;
                    if (m_rnw) begin
                        mem_din = rd_mem(m_addr);
                    end else begin
                        mem[m_addr] = m_data;
                        wr_addr_q.push_back(m_addr);
                        wr_data_q.push_back(m_data);
                        if (wr_cnt.exists(m_addr)) wr_cnt[m_addr]++;
                        else wr_cnt[m_addr] = 1;
                    end
                end else begin
                    m_cnt--;
                end
            end
            if (mem_req) begin
                chk("single_outstanding", {63'b0, m_pend}, 64'd0);
                req_cnt++;
                m_pend = 1'b1;
                m_cnt  = $urandom_range(mem_lat_max, mem_lat_min);
                m_addr = mem_addr;
                m_data = mem_dout;
                m_rnw  = mem_rnw;
            end
        end
    end

    // ---------------- source / sink / monitor ----------------
    logic [31:0] src_q[$];
    int unsigned src_lat_max = 0, src_wait = 0, src_cnt = 0;
    initial begin
        src_ack  = 1'b0;
        src_data = 32'h0;
        forever begin
            @(negedge clk);
            src_ack = 1'b0;
            if (src_req) begin
                if (src_cnt >= src_wait) begin
                    src_ack  = 1'b1;
                    src_data = (src_q.size() > 0) ? src_q.pop_front() : 32'hA5A5A5A5;
                    src_cnt  = 0;
                    src_wait = $urandom_range(src_lat_max, 0);
                end else begin
                    src_cnt++;
                end
            end else begin
                src_cnt = 0;
            end
        end
    end

    logic [31:0] snk_got[$];
    int unsigned snk_lat = 0, snk_cnt = 0;
    initial begin
        snk_ack = 1'b0;
        forever begin
            @(negedge clk);
            snk_ack = 1'b0;
            if (snk_valid) begin
                if (snk_cnt >= snk_lat) begin
                    snk_ack = 1'b1;
                    snk_got.push_back(snk_data);
                    snk_cnt = 0;
                end else begin
                    snk_cnt++;
                end
            end else begin
                snk_cnt = 0;
            end
        end
    end

    int done_cnt = 0, err_cnt = 0, snkv_cnt = 0;
    initial forever begin
        @(negedge clk);
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (snk_valid) snkv_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_save(input logic [23:0] b, input logic [15:0] n);
        base_addr  = b;
        word_count = n;
        save_start = 1'b1;
        tick();
        save_start = 1'b0;
    endtask

    task automatic start_load(input logic [23:0] b);
        base_addr  = b;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic wait_end(input string name, input int budget, output bit d, output bit e);
        int d0, e0, c;
        d0 = done_cnt;
        e0 = err_cnt;
        c  = 0;
        while (done_cnt == d0 && err_cnt == e0 && c < budget) begin
            tick();
            c++;
        end
        if (done_cnt == d0 && err_cnt == e0) chk({name, "_timeout"}, 64'd0, 64'd1);
        d = (done_cnt != d0);
        e = (err_cnt != e0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_src_req"}, src_req, 0);
        chk({tag, "_snk_valid"}, snk_valid, 0);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_rnw"}, mem_rnw, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_dout"}, mem_dout, 0);
        chk({tag, "_load_count"}, load_count, 0);
        chk({tag, "_snk_data"}, snk_data, 0);
    endtask

    // Reference: a save of w[] at b produces payload writes in order, then length, then magic.
    task automatic save_and_check(input string tag, input logic [23:0] b, input int n,
                                  input bit fixed, output logic [31:0] w[$]);
        logic [23:0] ea[$];
        logic [31:0] ed[$];
        int          r0;
        bit          d, e;
        w.delete();
        for (int i = 0; i < n; i++) w.push_back(fixed ? 32'h11111111 * (i + 1) : $urandom);
        src_q = w;
        wr_addr_q.delete();
        wr_data_q.delete();
        r0 = req_cnt;
        start_save(b, 16'(n));
        wait_end(tag, 4000, d, e);
        chk({tag, "_done"}, d, 1);
        chk({tag, "_error"}, e, 0);
        chk({tag, "_busy_after"}, busy, 0);
        for (int i = 0; i < n; i++) begin
            ea.push_back(b + 24'd4 + 24'(2 * i));
            ed.push_back(w[i]);
        end
        ea.push_back(b + 24'd2);
        ed.push_back({16'h0, 16'(n)});
        ea.push_back(b);
        ed.push_back(MAGIC_W);
        chk({tag, "_nreq"}, req_cnt - r0, n + 2);
        chk({tag, "_nwrites"}, wr_addr_q.size(), ea.size());
        foreach (ea[k]) begin
            if (k < wr_addr_q.size()) begin
                chk($sformatf("%s_wr%0d_addr", tag, k), wr_addr_q[k], ea[k]);
                chk($sformatf("%s_wr%0d_data", tag, k), wr_data_q[k], ed[k]);
            end
        end
    endtask

    task automatic load_and_check(input string tag, input logic [23:0] b, input bit exp_ok,
                                  input logic [31:0] exp_w[$]);
        bit d, e;
        snk_got.delete();
        start_load(b);
        wait_end(tag, 4000, d, e);
        chk({tag, "_done"}, d, exp_ok);
        chk({tag, "_error"}, e, !exp_ok);
        if (exp_ok) begin
            chk({tag, "_load_count"}, load_count, exp_w.size());
            chk({tag, "_nwords"}, snk_got.size(), exp_w.size());
            foreach (exp_w[i])
                if (i < snk_got.size()) chk($sformatf("%s_w%0d", tag, i), snk_got[i], exp_w[i]);
        end else begin
            chk({tag, "_no_words"}, snk_got.size(), 0);
        end
    endtask

    typedef struct {
        bit          is_load;
        logic [15:0] wc;
        logic [31:0] h0;
        logic [31:0] h1;
        bit          exp_err;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    initial begin
        logic [31:0] img[$];
        logic [31:0] ew[$];
        logic [23:0] b;
        int          r0, e0, d0, v0, rr0, c;
        bit          d, e, ok;
        logic [31:0] h1;

        vecs[0]  = '{1'b0, 16'd0,     32'h0, 32'h0, 1'b1};
        vecs[1]  = '{1'b0, 16'd32769, 32'h0, 32'h0, 1'b1};
        vecs[2]  = '{1'b0, 16'hFFFF,  32'h0, 32'h0, 1'b1};
        vecs[3]  = '{1'b0, 16'd32768, 32'h0, 32'h0, 1'b0};
        vecs[4]  = '{1'b0, 16'd1,     32'h0, 32'h0, 1'b0};
        vecs[5]  = '{1'b1, 16'd0, MAGIC_W,         32'd2,          1'b0};
        vecs[6]  = '{1'b1, 16'd0, MAGIC_W ^ 32'h1, 32'd2,          1'b1};
        vecs[7]  = '{1'b1, 16'd0, MAGIC_W,         32'd0,          1'b1};
        vecs[8]  = '{1'b1, 16'd0, MAGIC_W,         32'd32769,      1'b1};
        vecs[9]  = '{1'b1, 16'd0, MAGIC_W,         32'h0001_0002,  1'b1};
        vecs[10] = '{1'b1, 16'd0, MAGIC_W,         32'd1,          1'b0};

        reset_n    = 1'b0;
        save_start = 1'b0;
        load_start = 1'b0;
        abort      = 1'b0;
        base_addr  = 24'h0;
        word_count = 16'h0;
        tick();
        tick();
        chk_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // Directed save of three words, 1-cycle source ack.
        mem_lat_min = 0;
        mem_lat_max = 2;
        src_lat_max = 0;
        save_and_check("save3", 24'h000100, 3, 1'b1, img);

        // Load it back with a slow sink.
        snk_lat = 4;
        e0 = err_cnt;
        load_and_check("load3", 24'h000100, 1'b1, img);
        chk("load3_err_total", err_cnt - e0, 0);
        snk_lat = 0;

        // Bad magic: one request, no sink traffic.
        mem[24'h000200] = 32'hDEADBEEF;
        r0 = req_cnt;
        v0 = snkv_cnt;
        ew.delete();
        load_and_check("badmagic", 24'h000200, 1'b0, ew);
        chk("badmagic_nreq", req_cnt - r0, 1);
        chk("badmagic_snkv", snkv_cnt - v0, 0);

        // Reset while a header read is outstanding; its late ready must be ignored.
        mem[24'h000400] = MAGIC_W;
        mem[24'h000402] = 32'd2;
        mem_lat_min = 6;
        mem_lat_max = 6;
        start_load(24'h000400);
        tick();
        rr0 = ready_cnt;
        reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        tick();
        reset_n = 1'b1;
        d0 = done_cnt;
        e0 = err_cnt;
        v0 = snkv_cnt;
        c  = 0;
        while (ready_cnt == rr0 && c < 30) begin
            tick();
            c++;
        end
        chk("midreset_late_ready_seen", ready_cnt - rr0, 1);
        tick();
        tick();
        chk("midreset_busy", busy, 0);
        chk("midreset_no_done", done_cnt - d0, 0);
        chk("midreset_no_err", err_cnt - e0, 0);
        chk("midreset_no_snkv", snkv_cnt - v0, 0);
        mem_lat_min = 0;
        mem_lat_max = 2;
        save_and_check("postreset", 24'h000500, 2, 1'b0, img);

        // Table: start-time length legality and header validation.
        for (int v = 0; v < NV; v++) begin
            if (!vecs[v].is_load) begin
                src_q.delete();
                r0 = req_cnt;
                start_save(24'h000900, vecs[v].wc);
                chk($sformatf("vec%0d_error", v), error, vecs[v].exp_err);
                chk($sformatf("vec%0d_busy", v), busy, !vecs[v].exp_err);
                if (busy) begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    wait_end($sformatf("vec%0d_abort", v), 20, d, e);
                    chk($sformatf("vec%0d_abort_err", v), e, 1);
                end
                tick();
                tick();
                chk($sformatf("vec%0d_nreq", v), req_cnt - r0, 0);
                chk($sformatf("vec%0d_idle", v), busy, 0);
            end else begin
                mem[24'h000800] = vecs[v].h0;
                mem[24'h000802] = vecs[v].h1;
                ew.delete();
                for (int i = 0; i < 4; i++) begin
                    mem[24'h000804 + 24'(2 * i)] = $urandom;
                    if (i < int'(vecs[v].h1[15:0])) ew.push_back(mem[24'h000804 + 24'(2 * i)]);
                end
                load_and_check($sformatf("vec%0d", v), 24'h000800, !vecs[v].exp_err, ew);
            end
        end

        // Abort in the cycle the payload word 1 request is issued.
        mem_lat_min = 3;
        mem_lat_max = 3;
        src_lat_max = 0;
        src_q.delete();
        src_q.push_back(32'hA0A0A0A0);
        src_q.push_back(32'hB1B1B1B1);
        src_q.push_back(32'hC2C2C2C2);
        r0 = req_cnt;
        e0 = err_cnt;
        start_save(24'h000300, 16'd3);
        c = 0;
        while (!(mem_req && mem_addr == 24'h000306) && c < 200) begin
            tick();
            c++;
        end
        chk("abort_found_req1", {63'b0, mem_req}, 64'd1);
        rr0   = ready_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_src_req_low", src_req, 0);
        chk("abort_busy_waiting", busy, 1);
        wait_end("abort", 50, d, e);
        chk("abort_err", e, 1);
        chk("abort_ready_before_err", ready_cnt - rr0, 1);
        repeat (10) tick();
        chk("abort_nreq", req_cnt - r0, 2);
        chk("abort_err_total", err_cnt - e0, 1);
        chk("abort_hdr0_unwritten", wr_cnt.exists(24'h000300), 0);
        mem_lat_min = 0;
        mem_lat_max = 2;
        ew.delete();
        load_and_check("abort_load", 24'h000300, 1'b0, ew);

        // Random save/load pairs, with occasional header corruption and address wrap.
        for (int it = 0; it < 16; it++) begin
            b = ($urandom_range(3, 0) == 0) ? 24'hFFFFF8 : (24'($urandom) & 24'hFFFFFC);
            mem_lat_max = $urandom_range(3, 0);
            src_lat_max = $urandom_range(3, 0);
            snk_lat     = $urandom_range(3, 0);
            save_and_check($sformatf("rnd%0d_save", it), b, $urandom_range(6, 1), 1'b0, img);
            if (it % 4 == 3) begin
                if (it % 8 == 3) mem[b] = mem[b] ^ (32'h1 << $urandom_range(31, 0));
                else mem[b + 24'd2] = 32'h0;
            end
            h1 = rd_mem(b + 24'd2);
            ok = (rd_mem(b) == MAGIC_W) && (h1[31:16] == 16'h0) && (h1[15:0] != 16'h0) &&
                 (h1[15:0] <= 16'd32768);
            load_and_check($sformatf("rnd%0d_load", it), b, ok, img);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
